// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared register-file geometry and pipeline payload widths
package operand_fetch_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW = $clog2(NREG);
    localparam int OPW = 8;
    localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// reg_scoreboard: busy bit per register with same-cycle writeback clear folded into lookups
module reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [AW-1:0] set_addr,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    input  logic [AW-1:0] rd,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          rd_busy
);
    logic [NREG-1:0] busy;

    function automatic logic pending(input logic [AW-1:0] a);
        return a != REG_ZERO && busy[a] && !(clr_en && clr_addr == a);
    endfunction

    assign rs1_busy = pending(rs1);
    assign rs2_busy = pending(rs2);
    assign rd_busy  = pending(rd);

    // set is written last so it wins over a clear of the same register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (clr_en && clr_addr != REG_ZERO) busy[clr_addr] <= 1'b0;
            if (set_en && set_addr != REG_ZERO) busy[set_addr] <= 1'b1;
        end
    end
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: register-read stage with writeback bypass and busy-bit hazard stall
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [OPW-1:0]  id_op,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_rd_we,
    output logic [AW-1:0]   addr1,
    output logic [AW-1:0]   addr2,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [OPW-1:0]  ex_op,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [AW-1:0]   ex_rd,
    output logic            ex_rd_we
);
    logic rs1_busy, rs2_busy, rd_busy, accept;
    logic [XLEN-1:0] op1, op2;

    reg_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (accept && id_rd_we),
        .set_addr (id_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rd       (id_rd),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy),
        .rd_busy  (rd_busy)
    );

    assign addr1 = id_rs1;
    assign addr2 = id_rs2;

    assign id_ready = !rst && (!ex_valid || ex_ready) && !rs1_busy && !rs2_busy && !(id_rd_we && rd_busy);
    assign accept = id_valid && id_ready;

    // register zero wins over bypass, so a writeback to r0 can never forward
    always_comb begin
        op1 = id_rs1 == REG_ZERO ? '0 : (wb_valid && wb_addr == id_rs1) ? wb_data : data1;
        op2 = id_rs2 == REG_ZERO ? '0 : (wb_valid && wb_addr == id_rs2) ? wb_data : data2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid   <= 1'b0;
            ex_op      <= '0;
            ex_rs1_val <= '0;
            ex_rs2_val <= '0;
            ex_rd      <= '0;
            ex_rd_we   <= 1'b0;
        end else if (accept) begin
            ex_valid   <= 1'b1;
            ex_op      <= id_op;
            ex_rs1_val <= op1;
            ex_rs2_val <= op2;
            ex_rd      <= id_rd;
            ex_rd_we   <= id_rd_we;
        end else if (ex_ready) begin
            ex_valid   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed checks of reset, bypass, hazards, backpressure and r0 handling
module tb_operand_fetch;
    import operand_fetch_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_ready, id_rd_we;
    logic [OPW-1:0]  id_op;
    logic [AW-1:0]   id_rs1, id_rs2, id_rd, addr1, addr2;
    logic [XLEN-1:0] data1, data2;
    logic            wb_valid;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            ex_valid, ex_ready, ex_rd_we;
    logic [OPW-1:0]  ex_op;
    logic [XLEN-1:0] ex_rs1_val, ex_rs2_val;
    logic [AW-1:0]   ex_rd;
    logic [XLEN-1:0] rf [NREG];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd_we(id_rd_we),
        .addr1(addr1), .addr2(addr2), .data1(data1), .data2(data2),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
        .ex_rd(ex_rd), .ex_rd_we(ex_rd_we)
    );

    // register file model; r0 deliberately reads all-ones to prove the stage forces zero
    assign data1 = rf[addr1];
    assign data2 = rf[addr2];
    always @(posedge clk) if (wb_valid && wb_addr != 0) rf[wb_addr] <= wb_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] op, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] rd, input logic we);
        id_valid = 1'b1; id_op = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_rd_we = we;
    endtask

    task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
        wb_valid = v; wb_addr = a; wb_data = d;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) rf[i] = 32'h11 * i;
        rf[0] = 32'hFFFF_FFFF;
        rst = 1'b1; ex_ready = 1'b0;
        id_valid = 1'b0; id_op = '0; id_rs1 = '0; id_rs2 = '0; id_rd = '0; id_rd_we = 1'b0;
        wb(1'b0, 5'd0, 32'h0);
        step(); step();
        chk("rst_id_ready", {31'b0, id_ready}, 32'd0);
        rst = 1'b0; ex_ready = 1'b1; #1;
        chk("post_rst_ready", {31'b0, id_ready}, 32'd1);

        offer(8'hA5, 5'd1, 5'd2, 5'd6, 1'b1);
        step();
        id_valid = 1'b0; ex_ready = 1'b0;
        chk("pre_rst_valid", {31'b0, ex_valid}, 32'd1);
        chk("pre_rst_rs1", ex_rs1_val, 32'h11);
        rst = 1'b1;
        step(); step();
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_ex_op", {24'b0, ex_op}, 32'd0);
        chk("rst_ex_rs1", ex_rs1_val, 32'd0);
        chk("rst_ex_rs2", ex_rs2_val, 32'd0);
        chk("rst_ex_rd", {27'b0, ex_rd}, 32'd0);
        chk("rst_ex_rd_we", {31'b0, ex_rd_we}, 32'd0);
        chk("rst_ready_low", {31'b0, id_ready}, 32'd0);
        chk("rst_busy", dut.u_sb.busy, 32'd0);
        rst = 1'b0; ex_ready = 1'b1; #1;
        chk("release_ready", {31'b0, id_ready}, 32'd1);

        offer(8'h01, 5'd3, 5'd4, 5'd5, 1'b1);
        step();
        chk("basic_valid", {31'b0, ex_valid}, 32'd1);
        chk("basic_rs1", ex_rs1_val, 32'h33);
        chk("basic_rs2", ex_rs2_val, 32'h44);
        chk("basic_rd", {27'b0, ex_rd}, 32'd5);
        chk("basic_rd_we", {31'b0, ex_rd_we}, 32'd1);
        chk("basic_busy5", {31'b0, dut.u_sb.busy[5]}, 32'd1);

        offer(8'h02, 5'd5, 5'd4, 5'd8, 1'b0);
        #1;
        chk("raw_stall0", {31'b0, id_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("raw_stall", {31'b0, id_ready}, 32'd0);
            chk("raw_bubble", {31'b0, ex_valid}, 32'd0);
        end
        wb(1'b1, 5'd5, 32'h0000_DEAD);
        #1;
        chk("raw_release", {31'b0, id_ready}, 32'd1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("bypass_valid", {31'b0, ex_valid}, 32'd1);
        chk("bypass_rs1", ex_rs1_val, 32'h0000_DEAD);
        chk("bypass_rs2", ex_rs2_val, 32'h44);
        chk("bypass_busy5", {31'b0, dut.u_sb.busy[5]}, 32'd0);

        ex_ready = 1'b0;
        offer(8'h03, 5'd3, 5'd4, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", {31'b0, id_ready}, 32'd0);
            step();
            chk("bp_valid", {31'b0, ex_valid}, 32'd1);
            chk("bp_op", {24'b0, ex_op}, 32'h02);
            chk("bp_rs1", ex_rs1_val, 32'h0000_DEAD);
        end
        ex_ready = 1'b1; #1;
        chk("bp_release", {31'b0, id_ready}, 32'd1);
        step();
        chk("bp_new_op", {24'b0, ex_op}, 32'h03);
        chk("bp_new_rs1", ex_rs1_val, 32'h33);
        chk("bp_new_rd", {27'b0, ex_rd}, 32'd9);

        offer(8'h04, 5'd0, 5'd0, 5'd0, 1'b1);
        wb(1'b1, 5'd0, 32'h0000_BEEF);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("r0_rs1", ex_rs1_val, 32'd0);
        chk("r0_rs2", ex_rs2_val, 32'd0);
        chk("r0_busy", dut.u_sb.busy, 32'h0000_0200);

        offer(8'h05, 5'd1, 5'd2, 5'd7, 1'b1);
        step();
        chk("waw_set7", {31'b0, dut.u_sb.busy[7]}, 32'd1);
        offer(8'h07, 5'd3, 5'd4, 5'd7, 1'b1);
        wb(1'b1, 5'd7, 32'h77);
        #1;
        chk("setclr_ready", {31'b0, id_ready}, 32'd1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        chk("setclr_op", {24'b0, ex_op}, 32'h07);
        chk("setclr_busy7", {31'b0, dut.u_sb.busy[7]}, 32'd1);
        offer(8'h08, 5'd3, 5'd4, 5'd7, 1'b1);
        #1;
        chk("waw_stall", {31'b0, id_ready}, 32'd0);
        step();
        chk("waw_bubble", {31'b0, ex_valid}, 32'd0);
        offer(8'h09, 5'd7, 5'd7, 5'd7, 1'b1);
        wb(1'b1, 5'd7, 32'h0000_1234);
        #1;
        chk("dual_bypass_ready", {31'b0, id_ready}, 32'd1);
        step();
        wb(1'b0, 5'd0, 32'h0);
        id_valid = 1'b0;
        chk("dual_rs1", ex_rs1_val, 32'h0000_1234);
        chk("dual_rs2", ex_rs2_val, 32'h0000_1234);
        chk("dual_busy7", {31'b0, dut.u_sb.busy[7]}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
